// File: rtl/capture_sequencer.sv
// capture_sequencer: paces probe sampling, keeps a fixed pre-trigger history in a
// circular sample memory, watches for the configured trigger edges and then
// captures the post-trigger window, reporting where the trigger and record start are.
module capture_sequencer #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int PRETRIG = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [28:0]       PRESCALING_FACTOR,
  input  logic [1:0][15:0]  TRIGGER_KIND,
  input  logic [15:0]       probe_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } state_t;

  // The trigger sample is post-sample 1, so the post window holds DEPTH-PRETRIG writes.
  localparam int                POST_LEN   = DEPTH - PRETRIG;
  localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRETRIG);

  state_t              state;
  logic [28:0]         pf_l;
  logic [1:0][15:0]    tk_l;
  logic [28:0]         cnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   smp_cnt;
  logic [15:0]         prev;

  logic                active;
  logic                tick;
  logic [15:0]         rise;
  logic [15:0]         fall;
  logic [15:0]         match_vec;
  logic                fire;

  // Sample pacing and per-channel edge detection between the last and current sample.
  always_comb begin
    active    = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    tick      = active && (cnt == (pf_l - 29'd1));
    rise      = ~prev & probe_in;
    fall      = prev & ~probe_in;
    match_vec = (tk_l[0] & rise) | (tk_l[1] & fall);
    fire      = (tk_l == '0) || (|match_vec);
  end

  assign busy = active;
  assign done = (state == ST_DONE);

  // Acquisition state machine with registered memory write port and trigger bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pf_l       <= 29'd1;
      tk_l       <= '0;
      cnt        <= '0;
      wr_ptr     <= '0;
      smp_cnt    <= '0;
      prev       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      triggered  <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      mem_we <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              pf_l      <= (PRESCALING_FACTOR == 29'd0) ? 29'd1 : PRESCALING_FACTOR;
              tk_l      <= TRIGGER_KIND;
              cnt       <= '0;
              wr_ptr    <= '0;
              smp_cnt   <= '0;
              triggered <= 1'b0;
              state     <= ST_PREFILL;
            end
          end
          default: begin
            cnt <= tick ? 29'd0 : cnt + 29'd1;
            if (tick) begin
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= probe_in;
              wr_ptr    <= wr_ptr + 1'b1;
              prev      <= probe_in;
              case (state)
                ST_PREFILL: begin
                  if (smp_cnt == PRE_LAST) begin
                    smp_cnt <= '0;
                    state   <= ST_WAIT_TRIG;
                  end else begin
                    smp_cnt <= smp_cnt + 1'b1;
                  end
                end
                ST_WAIT_TRIG: begin
                  if (fire) begin
                    trig_addr  <= wr_ptr;
                    start_addr <= wr_ptr - PRE_OFFSET;
                    triggered  <= 1'b1;
                    smp_cnt    <= ADDR_W'(1);
                    state      <= (POST_LEN == 1) ? ST_DONE : ST_POST;
                  end
                end
                ST_POST: begin
                  if (smp_cnt == POST_LAST) begin
                    state <= ST_DONE;
                  end else begin
                    smp_cnt <= smp_cnt + 1'b1;
                  end
                end
                default: begin
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
